// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and ROM initiator; registers fetched words for decode with stall, LUT branch and halt handling.
module inst_fetch #(
  parameter int A = 10,
  parameter int W = 9,
  parameter logic [W-1:0] HALT_OP = 9'h1FF
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_stall,
  input  logic         i_branch_en,
  input  logic [2:0]   i_branch_idx,
  output logic [A-1:0] o_inst_address,
  input  logic [W-1:0] i_inst_in,
  output logic [W-1:0] o_inst,
  output logic [A-1:0] o_inst_pc,
  output logic         o_inst_valid,
  output logic         o_done
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [A-1:0] LUT [8] = '{A'(0), A'(3), A'(6), A'(10), A'(13), A'(17), A'(20), {A{1'b1}}};
  state_t      r_state, w_state_nxt;
  logic [A-1:0] r_pc, w_pc_nxt, r_inst_pc, w_inst_pc_nxt;
  logic [W-1:0] r_inst, w_inst_nxt;
  logic         r_valid, w_valid_nxt;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_inst_pc <= w_inst_pc_nxt;
      r_valid   <= w_valid_nxt;
    end
  end
  // Branch beats stall beats fetch; a fetched halt word freezes the PC on itself.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    w_valid_nxt   = 1'b0;
    if (r_state != RUN) begin
      w_state_nxt = i_start ? RUN : r_state;
      w_pc_nxt    = i_start ? '0 : r_pc;
    end else if (i_branch_en) begin
      w_pc_nxt = LUT[i_branch_idx];
    end else if (!i_stall) begin
      w_inst_nxt    = i_inst_in;
      w_inst_pc_nxt = r_pc;
      w_valid_nxt   = 1'b1;
      w_state_nxt   = (i_inst_in == HALT_OP) ? HALT : RUN;
      w_pc_nxt      = (i_inst_in == HALT_OP) ? r_pc : r_pc + 1'b1;
    end
  end
  assign o_inst_address = r_pc;
  assign o_inst         = r_inst;
  assign o_inst_pc      = r_inst_pc;
  assign o_inst_valid   = r_valid;
  assign o_done         = (r_state == HALT);
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus randomized traffic against a cycle-level reference of the fetch rules.
module tb_inst_fetch;
  localparam int A = 10;
  localparam int W = 9;
  localparam logic [W-1:0] HALT_OP = 9'h1FF;
  logic clk = 0, reset = 1, start = 0, stall = 0, br = 0;
  logic [2:0] idx = 0;
  logic [A-1:0] addr, inst_pc;
  logic [W-1:0] inst_in, inst;
  logic valid, done;
  logic [W-1:0] rom [0:1023];
  logic [A-1:0] lut [8];
  int total = 0, bad = 0;
  bit m_run, m_halt, m_valid;
  logic [A-1:0] m_pc, m_ipc;
  logic [W-1:0] m_inst;

  always #5 clk = ~clk;
  assign inst_in = rom[addr];

  inst_fetch #(.A(A), .W(W), .HALT_OP(HALT_OP)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stall(stall),
    .i_branch_en(br), .i_branch_idx(idx), .o_inst_address(addr),
    .i_inst_in(inst_in), .o_inst(inst), .o_inst_pc(inst_pc),
    .o_inst_valid(valid), .o_done(done)
  );

  task automatic tick();
    bit run = m_run, halt = m_halt, v = 0;
    logic [A-1:0] pc = m_pc, ipc = m_ipc;
    logic [W-1:0] in = m_inst;
    if (reset) begin
      run = 0; halt = 0; pc = 0; ipc = 0; in = 0;
    end else if (!run) begin
      if (start) begin run = 1; halt = 0; pc = 0; end
    end else if (br) begin
      pc = lut[idx];
    end else if (!stall) begin
      in = rom[m_pc]; ipc = m_pc; v = 1;
      if (rom[m_pc] == HALT_OP) begin run = 0; halt = 1; end
      else pc = m_pc + 1'b1;
    end
    @(posedge clk);
    #1;
    m_run = run; m_halt = halt; m_pc = pc; m_ipc = ipc; m_inst = in; m_valid = v;
  endtask

  task automatic restart();
    reset = 1; start = 0; br = 0; stall = 0;
    tick();
    reset = 0; start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    start = 1'($urandom); stall = 1'($urandom); br = 1'($urandom); idx = 3'($urandom);
    tick(); tick();
    reset = 0; start = 0; stall = 0; br = 0;
    total++;
    if ({addr, inst, inst_pc, valid, done} !== '0) begin
      bad++; $display("FAIL reset_state: got addr=%0d inst=%h ipc=%0d v=%b d=%b want all zero", addr, inst, inst_pc, valid, done);
    end
  endtask

  task automatic test_straight();
    start = 1; tick(); start = 0;
    total++;
    if ({addr, valid, done} !== {A'(0), 1'b0, 1'b0}) begin
      bad++; $display("FAIL start: got addr=%0d v=%b d=%b want 0 0 0", addr, valid, done);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if ({inst, inst_pc, valid} !== {rom[k], A'(k), 1'b1}) begin
        bad++; $display("FAIL straight[%0d]: got inst=%h ipc=%0d v=%b want %h %0d 1", k, inst, inst_pc, valid, rom[k], k);
      end
    end
  endtask

  task automatic test_stall();
    restart();
    repeat (5) tick();
    total++;
    if (addr !== A'(5)) begin bad++; $display("FAIL stall_pre: got addr=%0d want 5", addr); end
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({addr, valid} !== {A'(5), 1'b0}) begin
        bad++; $display("FAIL stall[%0d]: got addr=%0d v=%b want 5 0", k, addr, valid);
      end
    end
    stall = 0; tick();
    total++;
    if ({inst, inst_pc, valid} !== {rom[5], A'(5), 1'b1}) begin
      bad++; $display("FAIL stall_post: got inst=%h ipc=%0d v=%b want %h 5 1", inst, inst_pc, valid, rom[5]);
    end
  endtask

  task automatic test_branch();
    tick();
    total++;
    if (addr !== A'(7)) begin bad++; $display("FAIL branch_pre: got addr=%0d want 7", addr); end
    for (int s = 0; s < 2; s++) begin
      br = 1; idx = 3; stall = 1'(s); tick(); br = 0; stall = 0;
      total++;
      if ({addr, valid} !== {A'(10), 1'b0}) begin
        bad++; $display("FAIL branch_flush[%0d]: got addr=%0d v=%b want 10 0", s, addr, valid);
      end
      tick();
      total++;
      if ({inst, inst_pc, valid} !== {rom[10], A'(10), 1'b1}) begin
        bad++; $display("FAIL branch_fetch[%0d]: got inst=%h ipc=%0d v=%b want %h 10 1", s, inst, inst_pc, valid, rom[10]);
      end
    end
  endtask

  task automatic test_halt();
    logic [W-1:0] saved = rom[4];
    rom[4] = HALT_OP;
    restart();
    repeat (5) tick();
    total++;
    if ({inst, inst_pc, valid, done, addr} !== {HALT_OP, A'(4), 1'b1, 1'b1, A'(4)}) begin
      bad++; $display("FAIL halt_enter: got inst=%h ipc=%0d v=%b d=%b addr=%0d want 1ff 4 1 1 4", inst, inst_pc, valid, done, addr);
    end
    start = 1'($urandom); stall = 1'($urandom); start = 0;
    tick(); stall = 0;
    total++;
    if ({addr, valid, done} !== {A'(4), 1'b0, 1'b1}) begin
      bad++; $display("FAIL halt_hold: got addr=%0d v=%b d=%b want 4 0 1", addr, valid, done);
    end
    start = 1; tick(); start = 0;
    total++;
    if ({addr, done} !== {A'(0), 1'b0}) begin
      bad++; $display("FAIL halt_restart: got addr=%0d d=%b want 0 0", addr, done);
    end
    repeat (4) tick();
    br = 1; idx = 1; tick(); br = 0;
    total++;
    if ({addr, valid, done} !== {A'(3), 1'b0, 1'b0}) begin
      bad++; $display("FAIL branch_beats_halt: got addr=%0d v=%b d=%b want 3 0 0", addr, valid, done);
    end
    rom[4] = saved;
  endtask

  task automatic test_wrap_reset();
    restart();
    br = 1; idx = 7; tick(); br = 0;
    total++;
    if (addr !== A'(1023)) begin bad++; $display("FAIL wrap_branch: got addr=%0d want 1023", addr); end
    tick();
    total++;
    if ({inst_pc, addr, valid} !== {A'(1023), A'(0), 1'b1}) begin
      bad++; $display("FAIL wrap_top: got ipc=%0d addr=%0d v=%b want 1023 0 1", inst_pc, addr, valid);
    end
    tick();
    total++;
    if ({inst, inst_pc} !== {rom[0], A'(0)}) begin
      bad++; $display("FAIL wrap_zero: got inst=%h ipc=%0d want %h 0", inst, inst_pc, rom[0]);
    end
    reset = 1; tick(); reset = 0;
    total++;
    if ({addr, inst, inst_pc, valid, done} !== '0) begin
      bad++; $display("FAIL reset_mid_run: got addr=%0d inst=%h ipc=%0d v=%b d=%b want all zero", addr, inst, inst_pc, valid, done);
    end
    tick();
    total++;
    if ({addr, valid, done} !== '0) begin
      bad++; $display("FAIL reset_idle: got addr=%0d v=%b d=%b want 0 0 0", addr, valid, done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1024; i++) rom[i] = ($urandom_range(0, 11) == 0) ? HALT_OP : 9'($urandom_range(0, 9'h1FE));
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 6) == 0);
      idx = 3'($urandom);
      tick();
      total++;
      if ({addr, inst, inst_pc, valid, done} !== {m_pc, m_inst, m_ipc, m_valid, m_halt}) begin
        bad++; $display("FAIL random[%0d]: got addr=%0d inst=%h ipc=%0d v=%b d=%b want %0d %h %0d %b %b",
                        c, addr, inst, inst_pc, valid, done, m_pc, m_inst, m_ipc, m_valid, m_halt);
      end
    end
    reset = 0; start = 0; stall = 0; br = 0;
  endtask

  initial begin
    lut = '{A'(0), A'(3), A'(6), A'(10), A'(13), A'(17), A'(20), A'(1023)};
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 9'h1FE));
    test_reset();
    test_straight();
    test_stall();
    test_branch();
    test_halt();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
